// File: rtl/spike_event_scheduler.sv
// -----------------------------------------------------------------------------
// spike_event_scheduler
//
// Sequencer and arbiter that is the only master of the neuron adder unit's
// register port. It shares that port between the RISC-V host (single reads and
// writes) and an input-spike event stream. For each spike event it runs one
// integration step:
//   - read the synapse weight and the membrane potential;
//   - write back the saturated sum;
//   - check the adder unit's spike flag, and on a spike clear the membrane and
//     count an output spike.
//
// Optional feature macro: SPIKE_SCHED_LEAK_EN
//   When defined, the membrane potential is decremented by LEAK (floored at 0)
//   once per event, before the weight is added. Cycle timing is the same in
//   both builds.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   host_read/_write    host request strobes, held until host_ready
//   host_addr/_data_in  host address / write data
//   host_data_out       last host read data, held between reads
//   host_ready          one-cycle host completion pulse
//   evt_valid/evt_addr  pending spike event and its synapse (weight) index
//   evt_ready           one-cycle event acceptance pulse
//   au_read/au_write    adder unit strobes (one-cycle, never both high)
//   au_addr/au_data_in  adder unit address / write data, 0 when no strobe
//   au_data_out         adder unit read data, valid the cycle after au_read
//   au_spike_detected   adder unit spike flag, valid the cycle after a
//                       membrane write
//   spike_out           one-cycle pulse per output spike
//   spike_count         wrapping output spike counter
//   evt_err             sticky flag: an event addressed the membrane or beyond
//   busy                high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module spike_event_scheduler #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 16,
    parameter int MEMBRANE_ADDR = 63,
    parameter int LEAK          = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_read,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    output logic [DATA_WIDTH-1:0] host_data_out,
    output logic                  host_ready,
    input  logic                  evt_valid,
    input  logic [ADDR_WIDTH-1:0] evt_addr,
    output logic                  evt_ready,
    output logic                  au_read,
    output logic                  au_write,
    output logic [ADDR_WIDTH-1:0] au_addr,
    output logic [DATA_WIDTH-1:0] au_data_in,
    input  logic [DATA_WIDTH-1:0] au_data_out,
    input  logic                  au_spike_detected,
    output logic                  spike_out,
    output logic [15:0]           spike_count,
    output logic                  evt_err,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, H_WR, H_RD, H_RDW,
        E_RW, E_CW, E_RV, E_CV, E_WR, E_CHK, E_CLR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MEMBRANE_A = ADDR_WIDTH'(MEMBRANE_ADDR);
    localparam logic [DATA_WIDTH-1:0] LEAK_D     = DATA_WIDTH'(LEAK);

    state_t                state;
    logic                  last_host;
    logic [DATA_WIDTH-1:0] weight;

    logic                  au_read_r;
    logic                  au_write_r;
    logic [ADDR_WIDTH-1:0] au_addr_r;
    logic [DATA_WIDTH-1:0] au_data_r;

    logic                  host_req;
    logic                  evt_req;
    logic                  grant_evt;

    logic [DATA_WIDTH-1:0] v_eff;
    logic [DATA_WIDTH:0]   sum_wide;
    logic [DATA_WIDTH-1:0] sum_sat;

    // A request whose ready pulse is still showing has already been served;
    // the requester drops it on the edge that ends the pulse, so it must not
    // win a second grant on that same edge.
    assign host_req  = (host_read | host_write) & ~host_ready;
    assign evt_req   = evt_valid & ~evt_ready;
    // Alternating priority: the event wins a tie only if the host went last.
    assign grant_evt = evt_req & (~host_req | last_host);

    // Membrane value as seen by the adder, optionally leaked first.
`ifdef SPIKE_SCHED_LEAK_EN
    assign v_eff = (au_data_out > LEAK_D) ? (au_data_out - LEAK_D) : '0;
`else
    logic [DATA_WIDTH-1:0] unused_leak;
    assign unused_leak = LEAK_D;
    assign v_eff       = au_data_out;
`endif

    // Unsigned add with one guard bit; a carry out means clamp to all-ones.
    assign sum_wide = {1'b0, v_eff} + {1'b0, weight};
    assign sum_sat  = sum_wide[DATA_WIDTH] ? '1 : sum_wide[DATA_WIDTH-1:0];

    // The strobe bus is masked by reset so that no write can leave the block
    // in the reset cycle itself, before the registers have been cleared.
    assign au_read    = au_read_r  & ~reset;
    assign au_write   = au_write_r & ~reset;
    assign au_addr    = reset ? '0 : au_addr_r;
    assign au_data_in = reset ? '0 : au_data_r;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_host     <= 1'b0;
            weight        <= '0;
            au_read_r     <= 1'b0;
            au_write_r    <= 1'b0;
            au_addr_r     <= '0;
            au_data_r     <= '0;
            host_data_out <= '0;
            host_ready    <= 1'b0;
            evt_ready     <= 1'b0;
            spike_out     <= 1'b0;
            spike_count   <= '0;
            evt_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults make
            // every strobe and pulse a single cycle and are overridden below
            // only in the state that raises them.
            au_read_r  <= 1'b0;
            au_write_r <= 1'b0;
            au_addr_r  <= '0;
            au_data_r  <= '0;
            host_ready <= 1'b0;
            evt_ready  <= 1'b0;
            spike_out  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_evt) begin
                        evt_ready <= 1'b1;
                        last_host <= 1'b0;
                        if (evt_addr >= MEMBRANE_A) begin
                            // Out-of-range event: accept and drop it.
                            evt_err <= 1'b1;
                        end else begin
                            au_read_r <= 1'b1;
                            au_addr_r <= evt_addr;
                            state     <= E_RW;
                        end
                    end else if (host_req) begin
                        last_host <= 1'b1;
                        au_addr_r <= host_addr;
                        if (host_read) begin
                            au_read_r <= 1'b1;
                            state     <= H_RD;
                        end else begin
                            au_write_r <= 1'b1;
                            au_data_r  <= host_data_in;
                            host_ready <= 1'b1;
                            state      <= H_WR;
                        end
                    end
                end
                H_WR:  state <= IDLE;
                H_RD:  state <= H_RDW;
                H_RDW: begin
                    host_data_out <= au_data_out;
                    host_ready    <= 1'b1;
                    state         <= IDLE;
                end
                E_RW:  state <= E_CW;
                E_CW: begin
                    weight    <= au_data_out;
                    au_read_r <= 1'b1;
                    au_addr_r <= MEMBRANE_A;
                    state     <= E_RV;
                end
                E_RV:  state <= E_CV;
                E_CV: begin
                    // Membrane data is on au_data_out now; the sum is formed
                    // directly from it and goes out with the write strobe.
                    au_write_r <= 1'b1;
                    au_addr_r  <= MEMBRANE_A;
                    au_data_r  <= sum_sat;
                    state      <= E_WR;
                end
                E_WR:  state <= E_CHK;
                E_CHK: begin
                    if (au_spike_detected) begin
                        au_write_r  <= 1'b1;
                        au_addr_r   <= MEMBRANE_A;
                        spike_out   <= 1'b1;
                        spike_count <= spike_count + 16'd1;
                        state       <= E_CLR;
                    end else begin
                        state <= IDLE;
                    end
                end
                E_CLR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spike_event_scheduler
//
// Directed and randomized bench for spike_event_scheduler. A behavioural
// adder unit (register file plus a threshold spike flag) sits on the au_*
// port. A reference model tracks the expected register contents and spike
// count at the level of whole transactions (one host access, one event).
// -----------------------------------------------------------------------------
module tb_spike_event_scheduler;

    localparam int THRESHOLD = 1000;
    localparam int LEAK      = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_read, host_write;
    logic [5:0]  host_addr;
    logic [15:0] host_data_in, host_data_out;
    logic        host_ready;
    logic        evt_valid;
    logic [5:0]  evt_addr;
    logic        evt_ready;
    logic        au_read, au_write;
    logic [5:0]  au_addr;
    logic [15:0] au_data_in;
    logic [15:0] au_data_out;
    logic        au_spike_detected;
    logic        spike_out;
    logic [15:0] spike_count;
    logic        evt_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Reference state.
    int ref_mem [64];
    int ref_count = 0;
    logic [15:0] last_wr;
    logic [15:0] exp_wr_t;
    logic        exp_spk_t;

    // Behavioural adder unit.
    logic [15:0] au_mem [64];

    always #5 clk = ~clk;

    spike_event_scheduler #(
        .ADDR_WIDTH(6), .DATA_WIDTH(16), .MEMBRANE_ADDR(63), .LEAK(LEAK)
    ) dut (
        .clk(clk), .reset(reset),
        .host_read(host_read), .host_write(host_write),
        .host_addr(host_addr), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .host_ready(host_ready),
        .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
        .au_read(au_read), .au_write(au_write), .au_addr(au_addr),
        .au_data_in(au_data_in), .au_data_out(au_data_out),
        .au_spike_detected(au_spike_detected),
        .spike_out(spike_out), .spike_count(spike_count),
        .evt_err(evt_err), .busy(busy)
    );

    always @(posedge clk) begin
        if (au_read)  au_data_out <= au_mem[au_addr];
        if (au_write) au_mem[au_addr] <= au_data_in;
        au_spike_detected <= au_write && (au_addr == 6'd63) && (int'(au_data_in) >= THRESHOLD);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus rules that hold in every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_exclusive", au_read & au_write, 0);
            if (!au_read && !au_write)
                check("bus_zero_when_idle", {au_addr, au_data_in}, 0);
        end
    end

    // One integration step: optional leak, saturating add, threshold spike.
    task automatic ref_event(input logic [5:0] a, output logic [15:0] wr, output logic spk);
        int v;
        int s;
        v = ref_mem[63];
`ifdef SPIKE_SCHED_LEAK_EN
        v = (v > LEAK) ? v - LEAK : 0;
`endif
        s = v + ref_mem[a];
        if (s > 65535) s = 65535;
        wr  = 16'(s);
        spk = (s >= THRESHOLD);
        ref_mem[63] = spk ? 0 : s;
        if (spk) ref_count = (ref_count + 1) % 65536;
    endtask

    task automatic host_wr(input logic [5:0] a, input logic [15:0] d);
        int w;
        host_write = 1'b1; host_addr = a; host_data_in = d; w = 0;
        do begin @(negedge clk); w++; end while (!host_ready && w < 30);
        check("host_wr_ready_latency", w, 1);
        check("host_wr_strobe", {au_write, au_read, au_addr, au_data_in}, {1'b1, 1'b0, a, d});
        host_write = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
    endtask

    task automatic host_rd(input logic [5:0] a);
        int w;
        host_read = 1'b1; host_addr = a; w = 0;
        do begin @(negedge clk); w++; end while (!host_ready && w < 30);
        check("host_rd_ready_latency", w, 3);
        check("host_rd_data", host_data_out, ref_mem[a]);
        host_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_event(input logic [5:0] a);
        int w, lat, nrd, nwr, nspk;
        logic [15:0] got_wr, exp_wr;
        logic exp_spk, seen;
        evt_valid = 1'b1; evt_addr = a; w = 0;
        do begin @(negedge clk); w++; end while (!evt_ready && w < 30);
        check("evt_ready_latency", w, 1);
        evt_valid = 1'b0;
        if (a >= 6'd63) begin
            check("bad_evt_no_access", {busy, au_read, au_write}, 0);
            check("bad_evt_err", evt_err, 1);
        end else begin
            ref_event(a, exp_wr, exp_spk);
            lat = 0; nrd = 0; nwr = 0; nspk = 0; got_wr = '0; seen = 1'b0;
            while (busy && lat < 30) begin
                if (au_write && au_addr == 6'd63 && !seen) begin
                    got_wr = au_data_in; seen = 1'b1;
                end
                if (au_read)   nrd++;
                if (au_write)  nwr++;
                if (spike_out) nspk++;
                lat++;
                @(negedge clk);
            end
            last_wr = got_wr;
            check("evt_latency", lat, exp_spk ? 7 : 6);
            check("evt_reads", nrd, 2);
            check("evt_writes", nwr, exp_spk ? 2 : 1);
            check("evt_sum", got_wr, exp_wr);
            check("evt_spike_pulses", nspk, exp_spk);
            check("membrane", au_mem[63], ref_mem[63]);
            check("spike_count", spike_count, ref_count);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        string seq;
        logic [5:0] ra;
        for (int i = 0; i < 64; i++) au_mem[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 0;
        reset = 1'b1; host_read = 1'b0; host_write = 1'b0; host_addr = '0;
        host_data_in = '0; evt_valid = 1'b0; evt_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, host_ready, evt_ready, au_read, au_write, spike_out, evt_err}, 0);
        check("reset_host_data", host_data_out, 0);
        check("reset_count", spike_count, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Host write then read back.
        host_wr(6'd5, 16'h0064);
        host_rd(6'd5);

        // Integrate to threshold with weight 100.
        host_wr(6'd63, 16'h0000);
        for (int i = 0; i < 11; i++) run_event(6'd5);
`ifndef SPIKE_SCHED_LEAK_EN
        check("t3_spike_count", spike_count, 1);
        check("t3_membrane_after_11", au_mem[63], 100);
`endif

        // Saturation.
        host_wr(6'd63, 16'hFFF0);
        host_wr(6'd2, 16'h0100);
        run_event(6'd2);
        check("t4_saturated_sum", last_wr, 16'hFFFF);

        // Out-of-range event sets the sticky error.
        run_event(6'd63);
        run_event(6'd5);
        check("t6_err_sticky", evt_err, 1);

`ifdef SPIKE_SCHED_LEAK_EN
        host_wr(6'd63, 16'h0000);
        host_wr(6'd3, 16'h0064);
        run_event(6'd3);
        check("leak_first", last_wr, 16'h0064);
        run_event(6'd3);
        check("leak_second", last_wr, 16'h00C7);
`endif

        // Reset in the middle of an event (membrane read phase).
        host_wr(6'd63, 16'h0000);
        evt_valid = 1'b1; evt_addr = 6'd5; w = 0;
        do begin @(negedge clk); w++; end while (!evt_ready && w < 30);
        evt_valid = 1'b0; w = 0;
        while (!(au_read && au_addr == 6'd63) && w < 30) begin @(negedge clk); w++; end
        check("t1_reached_membrane_read", au_read && (au_addr == 6'd63), 1);
        reset = 1'b1;
        #1;
        check("t1_no_write_reset_cycle", au_write, 0);
        @(negedge clk);
        check("t1_outputs_zero", {busy, host_ready, evt_ready, au_read, au_write, au_addr, au_data_in, spike_out, evt_err}, 0);
        check("t1_host_data_zero", host_data_out, 0);
        check("t1_count_zero", spike_count, 0);
        @(negedge clk);
        reset = 1'b0;
        ref_count = 0;
        @(negedge clk);
        check("t1_idle_after_reset", {au_write, busy}, 0);
        check("t1_membrane_untouched", au_mem[63], ref_mem[63]);
        run_event(6'd5);

        // Both requesters held from reset: grants must alternate.
        host_wr(6'd0, 16'h0000);
        host_wr(6'd63, 16'h0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; ref_count = 0;
        host_read = 1'b1; host_addr = 6'd5; evt_valid = 1'b1; evt_addr = 6'd0;
        seq = ""; w = 0;
        while (seq.len() < 8 && w < 300) begin
            @(negedge clk); w++;
            if (host_ready) begin
                seq = {seq, "H"};
                check("t5_host_data", host_data_out, ref_mem[5]);
            end
            if (evt_ready) begin
                seq = {seq, "E"};
                ref_event(6'd0, exp_wr_t, exp_spk_t);
            end
        end
        host_read = 1'b0; evt_valid = 1'b0;
        check("t5_alternation", seq == "HEHEHEHE", 1);
        w = 0;
        while (busy && w < 30) begin @(negedge clk); w++; end
        @(negedge clk);
        check("t5_membrane", au_mem[63], ref_mem[63]);

        // Randomized mix of host accesses and events.
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 3);
            ra = 6'($urandom_range(0, 63));
            case (op)
                0: host_wr(ra, $urandom_range(0, 1) ? 16'($urandom_range(0, 300)) : 16'($urandom));
                1: host_rd(ra);
                default: run_event(ra);
            endcase
        end
        run_event(6'd63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_event_scheduler.md
Name: spike_event_scheduler

Overview:
Sequencer and arbiter that owns the register port of the neuron adder unit and shares it between the RISC-V host and an input-spike event stream. For each spike event it runs the integration step:
- read the synapse weight, read the membrane potential;
- write back the saturated sum;
- sample the spike flag and, on a spike, clear the membrane and count the output spike.

It sits between the RISC-V bus slave and the adder unit. It is the only master of the adder unit's read/write port.

Parameters:
ADDR_WIDTH, 6, adder unit address width
DATA_WIDTH, 16, data width
MEMBRANE_ADDR, 63, adder unit address of membrane potential; weights at 0..MEMBRANE_ADDR-1
LEAK, 1, per-event leak decrement (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
host_read  in  1  host read request, held until host_ready
host_write  in  1  host write request, held until host_ready
host_addr  in  ADDR_WIDTH  host address
host_data_in  in  DATA_WIDTH  host write data
host_data_out  out  DATA_WIDTH  last host read data, held
host_ready  out  1  one-cycle host completion pulse
evt_valid  in  1  spike event pending
evt_addr  in  ADDR_WIDTH  synapse (weight) index of event
evt_ready  out  1  one-cycle event acceptance pulse
au_read  out  1  adder unit read strobe
au_write  out  1  adder unit write strobe
au_addr  out  ADDR_WIDTH  adder unit address
au_data_in  out  DATA_WIDTH  adder unit write data
au_data_out  in  DATA_WIDTH  adder unit read data, valid cycle after au_read
au_spike_detected  in  1  adder unit spike flag, valid cycle after membrane write
spike_out  out  1  one-cycle pulse per output spike
spike_count  out  16  output spike counter, wraps at 65535->0
evt_err  out  1  sticky: event with evt_addr >= MEMBRANE_ADDR
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; all outputs 0, including host_data_out, spike_count and evt_err.
  - An in-flight event or host access is abandoned. No au_write is issued in the reset cycle or the cycle after.
- Strobes: au_read and au_write are one-cycle, never both high. au_addr and au_data_in are valid only while a strobe is high; otherwise they are 0.
- States: IDLE, H_WR, H_RD, H_RDW, E_RW, E_CW, E_RV, E_CV, E_WR, E_CHK, E_CLR.
- IDLE grant:
  - Only one request pending: grant it.
  - Both pending: priority alternates. A last_host bit is set after a host grant and cleared after an event grant. If last_host=1 the event wins, else the host wins.
  - Reads take precedence over writes if both host strobes are high.
- Host write: IDLE->H_WR. au_write with host_addr/host_data_in; host_ready=1 the same cycle. Next state is IDLE.
- Host read: IDLE->H_RD issues au_read -> H_RDW. In H_RDW, capture au_data_out into host_data_out and pulse host_ready -> IDLE. Latency is 2 cycles from grant.
- Host requests arriving while busy: stalled (host_ready stays low) until a grant in IDLE.
- Event, evt_addr < MEMBRANE_ADDR:
  - evt_ready pulses in the IDLE grant cycle; latch evt_addr.
  - E_RW: au_read(weight). E_CW: latch weight.
  - E_RV: au_read(MEMBRANE_ADDR). E_CV: latch v.
  - E_WR: au_write(MEMBRANE_ADDR, sum). sum = v + weight, unsigned, saturating at 2^DATA_WIDTH-1.
  - E_CHK: sample au_spike_detected.
    - If 1: go to E_CLR, which does au_write(MEMBRANE_ADDR, 0), spike_out=1, spike_count+1, then IDLE.
    - If 0: go to IDLE.
  - Latency: 6 cycles after grant without a spike, 7 with a spike.
- Event, evt_addr >= MEMBRANE_ADDR: evt_ready pulses, the event is dropped, evt_err is set, state stays IDLE, and no adder unit access occurs.
- busy is low only in IDLE. A new grant can occur in the first IDLE cycle after completion.

Optional Feature:
SPIKE_SCHED_LEAK_EN
- Defined: in E_CV, v' = (v > LEAK) ? v - LEAK : 0, and sum = sat(v' + weight). The leak is applied once per event before the add.
- Undefined: there is no leak, and the LEAK parameter is unused. Cycle timing is identical in both builds.

Test Plan:
1. Reset held 2 cycles during an E_RV sequence -> all outputs 0, state IDLE, no au_write; next event runs normally.
2. Host write addr 5 = 0x0064, then host read addr 5 -> host_ready pulses on write cycle; read returns 0x0064 in host_data_out 2 cycles after grant.
3. Membrane 0x0000, weight[5]=0x0064, THRESHOLD 1000, 11 events on addr 5 (leak off) -> membrane 100..1000; au_spike_detected on 10th; spike_out once; membrane written 0; spike_count=1; membrane 100 after 11th.
4. Membrane 0xFFF0, weight[2]=0x0100 -> au_data_in on E_WR = 0xFFFF (saturation).
5. host_read and evt_valid held continuously from reset -> grants alternate host, event, host, event; neither starves; host stalled while busy.
6. evt_addr=63 -> evt_ready pulse, evt_err=1 and stays 1, no au_read/au_write; with SPIKE_SCHED_LEAK_EN and LEAK=1, membrane 0x0000 + weight 0x0064 -> 0x0064, next event -> 0x00C7.
